// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// fetch_controller_pkg : shared fetch types (state encodings, fetch entry)
// Revision: 1.0
// ============================================================================
package fetch_controller_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef enum logic [1:0] {
    FETCH_WAIT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : DEPTH-entry buffer of fetched {instr, pc} with push/pop/flush
// Revision: 1.0
// ============================================================================
module fetch_fifo
  import fetch_controller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !w_full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// fetch_controller : drives instruction memory PC, buffers words toward decode
// Revision: 1.0
// ============================================================================
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 1024,
  parameter int          DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rstn,
  output logic [PC_W-1:0]    mem_pc,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               mem_stop,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               halted
);

  localparam int                CNT_W       = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]    c_depth     = (CNT_W+1)'(DEPTH);
  localparam logic [PC_W-1:0]   c_mem_bytes = PC_W'(MEM_BYTES);

  fetch_state_e     r_state;
  logic [PC_W-1:0]  r_mem_pc;
  logic [PC_W-1:0]  r_req_pc;
  logic             r_inflight;
  logic             r_halted;

  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;
  logic             w_in_bound;
  logic             w_credit_ok;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;

  // Credit counts the word in flight so a response always has a free slot.
  assign w_in_bound  = (r_mem_pc < c_mem_bytes);
  assign w_credit_ok = (({1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}) < c_depth);
  assign w_issue     = (r_state == FETCH_RUN) && w_credit_ok && w_in_bound && !redirect_valid;
  assign w_push      = r_inflight && (r_state == FETCH_RUN) && !mem_stop && !redirect_valid;
  assign w_pop       = out_valid && out_ready;
  assign w_push_data = '{instr: mem_instr, pc: r_req_pc};

  assign mem_pc    = r_mem_pc;
  assign halted    = r_halted;
  assign out_valid = !w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= FETCH_WAIT;
      r_mem_pc   <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
    end else if (redirect_valid) begin
      r_state    <= FETCH_RUN;
      r_mem_pc   <= {redirect_pc[PC_W-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_mem_pc;
        r_mem_pc <= r_mem_pc + PC_W'(4);
      end
      case (r_state)
        FETCH_WAIT: r_state <= FETCH_RUN;
        FETCH_RUN: begin
          if ((r_inflight && mem_stop) || (!r_inflight && !w_in_bound)) begin
            r_state  <= FETCH_HALT;
            r_halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head      (w_head),
    .count     (w_count),
    .empty     (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// tb_fetch_controller : directed bench with instruction memory model
// Revision: 1.0
// ============================================================================
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] mem_pc;
  logic [31:0] mem_instr = '0;
  logic        mem_stop = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  int total = 0;
  int bad   = 0;

  logic [31:0] imem [256];
  logic [31:0] got [$];

  typedef struct {
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ehalt;
  } vec_t;

  vec_t vt [5];

  always #5 clk = ~clk;

  // One-cycle-latency memory; an all-zero word signals end of program.
  always @(posedge clk) begin
    if (mem_pc < 32'd1024) begin
      mem_instr <= imem[mem_pc[9:2]];
      mem_stop  <= (imem[mem_pc[9:2]] == 32'h0);
    end else begin
      mem_instr <= 32'h0;
      mem_stop  <= 1'b1;
    end
  end

  fetch_controller #(
    .RESET_PC  (32'h0),
    .MEM_BYTES (1024),
    .DEPTH     (4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mem_pc         (mem_pc),
    .mem_instr      (mem_instr),
    .mem_stop       (mem_stop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fill(input bit hole);
    for (int i = 0; i < 256; i++) imem[i] = {16'hC0DE, 16'(i * 4)};
    if (hole) imem[3] = 32'h0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int order_err;
    bit found;

    vt[0] = '{32'h43,  1'b1, 32'h40,  32'hC0DE0040, 1'b0};
    vt[1] = '{32'h20,  1'b0, 32'h20,  32'hC0DE0020, 1'b0};
    vt[2] = '{32'h3FF, 1'b1, 32'h3FC, 32'hC0DE03FC, 1'b1};
    vt[3] = '{32'h7,   1'b1, 32'h4,   32'hC0DE0004, 1'b0};
    vt[4] = '{32'h102, 1'b0, 32'h100, 32'hC0DE0100, 1'b0};

    rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    fill(1'b1);
    repeat (2) @(negedge clk);
    chk("rst_valid",  32'(out_valid), 32'd0);
    chk("rst_pc",     out_pc,         32'h0);
    chk("rst_instr",  out_instr,      32'h0);
    chk("rst_halted", 32'(halted),    32'd0);
    chk("rst_mempc",  mem_pc,         32'h0);

    // Straight line: 0,4,8 then a zero word at 12.
    out_ready = 1'b1;
    rstn = 1'b1;
    first = -1;
    got.delete();
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (out_valid) begin
        if (first < 0) first = c;
        got.push_back(out_pc);
      end
    end
    // One WAIT cycle, then issue, then the word becomes visible.
    chk("sl_first_cycle", 32'(first), 32'd3);
    chk("sl_count", 32'(got.size()), 32'd3);
    if (got.size() >= 3) begin
      chk("sl_pc0", got[0], 32'h0);
      chk("sl_pc1", got[1], 32'h4);
      chk("sl_pc2", got[2], 32'h8);
    end
    chk("sl_halted", 32'(halted), 32'd1);

    // Restart from halt.
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    cyc();
    chk("hr_halted", 32'(halted), 32'd0);
    redirect_valid = 1'b0;
    cyc();
    chk("hr_valid_early", 32'(out_valid), 32'd0);
    cyc();
    chk("hr_valid", 32'(out_valid), 32'd1);
    chk("hr_pc",    out_pc,         32'h20);

    // Backpressure.
    fill(1'b0);
    out_ready = 1'b0;
    do_reset();
    repeat (12) cyc();
    chk("bp_mempc", mem_pc,         32'd16);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head",  out_pc,         32'h0);
    out_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 8; k++) begin
      if (out_valid) got.push_back(out_pc);
      cyc();
    end
    chk("bp_count", 32'(got.size()), 32'd8);
    for (int k = 0; k < 6 && k < got.size(); k++) chk($sformatf("bp_pc%0d", k), got[k], 32'(k * 4));

    // Redirect with three entries held and one word in flight.
    out_ready = 1'b0;
    do_reset();
    repeat (5) cyc();
    chk("rd_head", out_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    cyc();
    chk("rd_flush", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("rd_gap", 32'(out_valid), 32'd0);
    cyc();
    chk("rd_valid", 32'(out_valid), 32'd1);
    chk("rd_pc",    out_pc,         32'h40);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("rd_next%0d", k), out_pc, 32'h40 + 32'(k * 4));
    end

    // Table of redirects.
    for (int i = 0; i < 5; i++) begin
      redirect_valid = 1'b1; redirect_pc = vt[i].rpc; out_ready = vt[i].rdy;
      cyc();
      chk($sformatf("tv%0d_flush", i),  32'(out_valid), 32'd0);
      chk($sformatf("tv%0d_halted", i), 32'(halted),    32'd0);
      redirect_valid = 1'b0; out_ready = 1'b1;
      cyc();
      chk($sformatf("tv%0d_gap", i), 32'(out_valid), 32'd0);
      cyc();
      chk($sformatf("tv%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tv%0d_pc", i),    out_pc,         vt[i].epc);
      chk($sformatf("tv%0d_instr", i), out_instr,      vt[i].einstr);
      repeat (3) cyc();
      chk($sformatf("tv%0d_halt_after", i), 32'(halted), 32'(vt[i].ehalt));
    end

    // Memory bound: every word nonzero.
    out_ready = 1'b1;
    do_reset();
    got.delete();
    for (int c = 0; c < 300; c++) begin
      cyc();
      if (out_valid) got.push_back(out_pc);
    end
    order_err = 0;
    for (int k = 0; k < got.size(); k++) if (got[k] !== 32'(k * 4)) order_err++;
    chk("bd_count",  32'(got.size()), 32'd256);
    chk("bd_order",  32'(order_err),  32'd0);
    if (got.size() > 0) chk("bd_last", got[got.size()-1], 32'h3FC);
    chk("bd_halted", 32'(halted), 32'd1);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    do_reset();
    repeat (4) cyc();
    chk("ar_queued", 32'(out_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_pc",    out_pc,         32'h0);
    chk("ar_mempc", mem_pc,         32'h0);
    @(negedge clk);
    rstn = 1'b1; out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc();
      if (out_valid) found = 1'b1;
    end
    chk("ar_found", 32'(found), 32'd1);
    chk("ar_first_pc", out_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
